// File: rtl/elem_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elem_cmd_pkg
//  Purpose  : Shared types for the element command issuer.
//             - 128-bit command layout.
//             - Field widths.
//             - FSM state constants.
//             - Modular trigger-time compare.
//  Revision : 1.0  initial release
// ============================================================================
package elem_cmd_pkg;

    localparam int TCNT_W = 27;
    localparam int ENV_W  = 12;
    localparam int FREQ_W = 9;
    localparam int PINI_W = 17;
    localparam int AMP_W  = 16;
    localparam int MODE_W = 2;
    localparam int RSVD_W = 17;

    // Everything the issuer keeps from a command (reserved bits excluded).
    // Declared MSB first, so trigt occupies bits [26:0].
    typedef struct packed {
        logic [MODE_W-1:0] mode;      // [110:109]
        logic [AMP_W-1:0]  ampy;      // [108:93]
        logic [AMP_W-1:0]  ampx;      // [92:77]
        logic [PINI_W-1:0] pini;      // [76:60]
        logic [FREQ_W-1:0] freqaddr;  // [59:51]
        logic [ENV_W-1:0]  envlength; // [50:39]
        logic [ENV_W-1:0]  envstart;  // [38:27]
        logic [TCNT_W-1:0] trigt;     // [26:0]
    } cmd_fields_t;

    typedef struct packed {
        logic [RSVD_W-1:0] rsvd;      // [127:111], ignored
        cmd_fields_t       f;
    } cmd_t;

    // Issuer FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        TD_ONTIME = 2'd0,
        TD_LATE   = 2'd1,
        TD_EARLY  = 2'd2
    } tdiff_e;

    // Classifies the current time against a trigger time.
    // The compare works modulo 2^TCNT_W:
    // - A difference in the lower half-range counts as "already passed".
    // - The upper half-range counts as "still in the future".
    // This makes counter wrap-around transparent.
    function automatic tdiff_e tdiff_state(input logic [TCNT_W-1:0] tcnt,
                                           input logic [TCNT_W-1:0] trigt);
        logic [TCNT_W-1:0] d;
        d = tcnt - trigt;
        if (d == '0)
            return TD_ONTIME;
        else if (!d[TCNT_W-1])
            return TD_LATE;
        else
            return TD_EARLY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elem_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : elem_cmd_issuer
//  Purpose  : Producer side of the element command interface.
//             - Takes one timestamped command at a time from a valid/ready
//               stream.
//             - Holds it until the shared time counter reaches its trigger
//               time.
//             - Then presents the decoded fields with a one-cycle cmdstb.
//             - Late and busy-collided fires pulse late_err and bump a
//               saturating counter.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             cmd/cmd_valid/cmd_ready - 128-bit command stream
//             tcnt, busy        - element time counter and busy flag
//             envstart..mode    - decoded fields, change only with cmdstb
//             cmdstb            - one-cycle strobe, fields valid
//             elem_reset        - reset delayed by one register
//             late_err/late_cnt - late/collision pulse and saturating count
//             idle              - no command held and none offered
//  Revision : 1.0  initial release
// ============================================================================
module elem_cmd_issuer
    import elem_cmd_pkg::*;
#(
    parameter int TCNTWIDTH      = 27,
    parameter int ENV_ADDRWIDTH  = 12,
    parameter int FREQ_ADDRWIDTH = 9,
    parameter int LATECNTWIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [127:0]              cmd,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [TCNTWIDTH-1:0]      tcnt,
    input  logic                      busy,
    output logic [ENV_ADDRWIDTH-1:0]  envstart,
    output logic [ENV_ADDRWIDTH-1:0]  envlength,
    output logic [FREQ_ADDRWIDTH-1:0] freqaddr,
    output logic [16:0]               pini,
    output logic [15:0]               ampx,
    output logic [15:0]               ampy,
    output logic [1:0]                mode,
    output logic                      cmdstb,
    output logic                      elem_reset,
    output logic                      late_err,
    output logic [LATECNTWIDTH-1:0]   late_cnt,
    output logic                      idle
);

    cmd_t        cmd_w;
    logic        unused_rsvd;
    state_t      state_q, state_d;
    cmd_fields_t held_q, held_d;
    tdiff_e      td_w;
    logic        accept_w;
    logic        fire_w;
    logic        late_w;

    logic                      cmdstb_q;
    logic                      late_err_q;
    logic                      elem_reset_q;
    logic [LATECNTWIDTH-1:0]   late_cnt_q;
    logic [ENV_ADDRWIDTH-1:0]  envstart_q;
    logic [ENV_ADDRWIDTH-1:0]  envlength_q;
    logic [FREQ_ADDRWIDTH-1:0] freqaddr_q;
    logic [16:0]               pini_q;
    logic [15:0]               ampx_q;
    logic [15:0]               ampy_q;
    logic [1:0]                mode_q;

    assign cmd_w       = cmd;
    assign unused_rsvd = ^cmd_w.rsvd;

    assign td_w = tdiff_state(tcnt, held_q.trigt);

    // Not ready in the strobe cycle right after a fire, which keeps strobes
    // at least three cycles apart; never ready while reset is asserted.
    assign cmd_ready = (state_q == ST_IDLE) && !cmdstb_q && !reset;
    assign accept_w  = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        fire_w  = 1'b0;
        late_w  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    held_d  = cmd_w.f;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                case (td_w)
                    TD_ONTIME: begin
                        if (busy)
                            state_d = ST_HOLD;
                        else
                            fire_w = 1'b1;
                    end
                    // Late fires go out regardless of busy
                    TD_LATE: begin
                        fire_w = 1'b1;
                        late_w = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HOLD: begin
                if (!busy) begin
                    fire_w = 1'b1;
                    late_w = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fire_w)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        elem_reset_q <= reset;
        if (reset) begin
            state_q     <= ST_IDLE;
            held_q      <= '0;
            cmdstb_q    <= 1'b0;
            late_err_q  <= 1'b0;
            late_cnt_q  <= '0;
            envstart_q  <= '0;
            envlength_q <= '0;
            freqaddr_q  <= '0;
            pini_q      <= '0;
            ampx_q      <= '0;
            ampy_q      <= '0;
            mode_q      <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            cmdstb_q   <= fire_w;
            late_err_q <= late_w;
            if (fire_w) begin
                envstart_q  <= held_q.envstart;
                envlength_q <= held_q.envlength;
                freqaddr_q  <= held_q.freqaddr;
                pini_q      <= held_q.pini;
                ampx_q      <= held_q.ampx;
                ampy_q      <= held_q.ampy;
                mode_q      <= held_q.mode;
            end
            if (late_w && (late_cnt_q != {LATECNTWIDTH{1'b1}}))
                late_cnt_q <= late_cnt_q + 1'b1;
        end
    end

    assign envstart   = envstart_q;
    assign envlength  = envlength_q;
    assign freqaddr   = freqaddr_q;
    assign pini       = pini_q;
    assign ampx       = ampx_q;
    assign ampy       = ampy_q;
    assign mode       = mode_q;
    assign cmdstb     = cmdstb_q;
    assign late_err   = late_err_q;
    assign late_cnt   = late_cnt_q;
    assign elem_reset = elem_reset_q;
    assign idle       = (state_q == ST_IDLE) && !cmd_valid;

endmodule
`default_nettype wire

// File: tb/tb_elem_cmd_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_elem_cmd_issuer
//  Purpose  : Self-checking bench for elem_cmd_issuer. Directed scenarios
//             followed by randomized traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_elem_cmd_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst   = 1'b1;
    logic [127:0] cmd   = '0;
    logic         valid = 1'b0;
    logic [26:0]  tcnt  = '0;
    logic         busy  = 1'b0;

    logic        ready, cmdstb, elem_reset, late_err, idle;
    logic [11:0] envstart, envlength;
    logic [8:0]  freqaddr;
    logic [16:0] pini;
    logic [15:0] ampx, ampy, late_cnt;
    logic [1:0]  mode;

    elem_cmd_issuer dut (
        .clk        (clk),
        .reset      (rst),
        .cmd        (cmd),
        .cmd_valid  (valid),
        .cmd_ready  (ready),
        .tcnt       (tcnt),
        .busy       (busy),
        .envstart   (envstart),
        .envlength  (envlength),
        .freqaddr   (freqaddr),
        .pini       (pini),
        .ampx       (ampx),
        .ampy       (ampy),
        .mode       (mode),
        .cmdstb     (cmdstb),
        .elem_reset (elem_reset),
        .late_err   (late_err),
        .late_cnt   (late_cnt),
        .idle       (idle)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (tcnt=%0d t=%0t)",
                     name, act, exp, tcnt, $time);
        end
    endtask

    // Build a command with the documented bit layout; reserved bits are junk
    function automatic logic [127:0] mk(input logic [26:0] t, input logic [11:0] es,
                                        input logic [11:0] el, input logic [8:0] fa,
                                        input logic [16:0] p, input logic [15:0] ax,
                                        input logic [15:0] ay, input logic [1:0] md);
        logic [127:0] c;
        c = {$urandom, $urandom, $urandom, $urandom};
        c[26:0]    = t;
        c[38:27]   = es;
        c[50:39]   = el;
        c[59:51]   = fa;
        c[76:60]   = p;
        c[92:77]   = ax;
        c[108:93]  = ay;
        c[110:109] = md;
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: one outstanding command, fire decided from the
    // modular distance between now and its trigger time.
    // ------------------------------------------------------------------
    bit          m_held, m_matched, m_gap, m_accepted;
    logic [26:0] m_trigt;
    logic [11:0] m_es, m_el;
    logic [8:0]  m_fa;
    logic [16:0] m_pini;
    logic [15:0] m_ax, m_ay;
    logic [1:0]  m_mode;

    logic        e_stb = 0, e_late = 0, e_erst = 0;
    logic [11:0] e_es = 0, e_el = 0;
    logic [8:0]  e_fa = 0;
    logic [16:0] e_pini = 0;
    logic [15:0] e_ax = 0, e_ay = 0, e_cnt = 0;
    logic [1:0]  e_mode = 0;

    logic [26:0] stb_t[$];
    int          late_n = 0;

    task automatic model_edge();
        bit          fire, lt, rdy;
        logic [26:0] d;
        fire = 0; lt = 0;
        m_accepted = 0;
        e_erst = rst;
        if (rst) begin
            m_held = 0; m_matched = 0; m_gap = 0;
            e_stb = 0; e_late = 0; e_cnt = 0;
            e_es = 0; e_el = 0; e_fa = 0; e_pini = 0; e_ax = 0; e_ay = 0; e_mode = 0;
        end else begin
            rdy   = !m_held && !m_gap;
            m_gap = 0;
            if (m_held) begin
                d = tcnt - m_trigt;
                if (m_matched) begin
                    if (!busy) begin fire = 1; lt = 1; end
                end else if (d == 0) begin
                    if (busy) m_matched = 1;
                    else      fire = 1;
                end else if (d < 27'h4000000) begin
                    fire = 1; lt = 1;
                end
            end else if (rdy && valid) begin
                m_held = 1; m_matched = 0; m_accepted = 1;
                m_trigt = cmd[26:0];    m_es = cmd[38:27];  m_el = cmd[50:39];
                m_fa = cmd[59:51];      m_pini = cmd[76:60]; m_ax = cmd[92:77];
                m_ay = cmd[108:93];     m_mode = cmd[110:109];
            end
            e_stb  = fire;
            e_late = lt;
            if (fire) begin
                e_es = m_es; e_el = m_el; e_fa = m_fa; e_pini = m_pini;
                e_ax = m_ax; e_ay = m_ay; e_mode = m_mode;
                m_held = 0; m_gap = 1;
                if (lt && e_cnt != 16'hffff) e_cnt = e_cnt + 1;
                stb_t.push_back(tcnt);
            end
            if (lt) late_n++;
        end
    endtask

    // One clock: combinational checks on the freshly driven inputs, then
    // the edge, then registered checks; tcnt advances afterwards.
    task automatic cycle();
        #1;
        chk("cmd_ready", ready, !rst && !m_held && !m_gap);
        if (!rst) chk("idle", idle, !m_held && !valid);
        @(posedge clk);
        model_edge();
        #1;
        chk("cmdstb", cmdstb, e_stb);
        chk("late_err", late_err, e_late);
        chk("late_cnt", late_cnt, e_cnt);
        chk("elem_reset", elem_reset, e_erst);
        chk("envstart", envstart, e_es);
        chk("envlength", envlength, e_el);
        chk("freqaddr", freqaddr, e_fa);
        chk("pini", pini, e_pini);
        chk("ampx", ampx, e_ax);
        chk("ampy", ampy, e_ay);
        chk("mode", mode, e_mode);
        tcnt = tcnt + 1;
    endtask

    task automatic run_until(input logic [26:0] t);
        for (int i = 0; i < 1000 && tcnt != t; i++) cycle();
        chk("run_until_bound", tcnt, t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, late0, acc;
        logic [26:0] tt;
        int off;

        // Reset
        rst = 1;
        repeat (3) cycle();
        chk("erst_in_reset", elem_reset, 1);
        rst = 0;
        cycle();
        chk("erst_after_reset", elem_reset, 0);
        chk("ready_after_reset", ready, 1);
        chk("idle_after_reset", idle, 1);
        chk("cnt_after_reset", late_cnt, 0);

        // On-time fire
        tcnt = 0;
        run_until(10);
        n = stb_t.size();
        valid = 1; cmd = mk(100, 12'h010, 12'h020, 9'h1a5, 17'h1abcd, 16'h7fff, 16'h8001, 2'd2);
        cycle();
        valid = 0;
        run_until(112);
        chk("ontime_count", stb_t.size() - n, 1);
        if (stb_t.size() > n) chk("ontime_time", stb_t[n], 100);
        chk("ontime_envstart", envstart, 12'h010);
        chk("ontime_envlength", envlength, 12'h020);
        chk("ontime_ampx", ampx, 16'h7fff);
        chk("ontime_late_cnt", late_cnt, 0);

        // Late
        tcnt = 80; n = stb_t.size(); late0 = late_n;
        valid = 1; cmd = mk(50, 12'h111, 12'h222, 9'h033, 17'h00444, 16'h5555, 16'h6666, 2'd1);
        cycle();
        valid = 0;
        repeat (4) cycle();
        chk("late_count", stb_t.size() - n, 1);
        if (stb_t.size() > n) chk("late_time", stb_t[n], 81);
        chk("late_pulses", late_n - late0, 1);
        chk("late_cnt_1", late_cnt, 1);

        // Wrap-around
        tcnt = 27'h7fffffb; n = stb_t.size();
        valid = 1; cmd = mk(3, 12'h0ab, 12'h0cd, 9'h0ef, 17'h10101, 16'h1234, 16'h4321, 2'd3);
        cycle();
        valid = 0;
        repeat (12) cycle();
        chk("wrap_count", stb_t.size() - n, 1);
        if (stb_t.size() > n) chk("wrap_time", stb_t[n], 3);
        chk("wrap_late_cnt", late_cnt, 1);

        // Collision with busy
        tcnt = 190; n = stb_t.size(); busy = 1;
        valid = 1; cmd = mk(200, 12'hfff, 12'h001, 9'h1ff, 17'h1ffff, 16'hffff, 16'h0001, 2'd0);
        cycle();
        valid = 0;
        run_until(210);
        busy = 0;
        repeat (4) cycle();
        chk("collide_count", stb_t.size() - n, 1);
        if (stb_t.size() > n) chk("collide_time", stb_t[n], 210);
        chk("collide_late_cnt", late_cnt, 2);

        // Back-to-back
        tcnt = 290; n = stb_t.size(); acc = 0;
        valid = 1; cmd = mk(300, 12'h300, 12'h030, 9'h003, 17'h00300, 16'h3000, 16'h0300, 2'd1);
        for (int i = 0; i < 40 && acc < 2; i++) begin
            cycle();
            if (m_accepted) begin
                acc++;
                cmd = mk(301, 12'h301, 12'h031, 9'h013, 17'h00301, 16'h3001, 16'h0301, 2'd2);
            end
        end
        valid = 0;
        chk("b2b_accepts", acc, 2);
        run_until(310);
        chk("b2b_count", stb_t.size() - n, 2);
        if (stb_t.size() > n + 1) begin
            chk("b2b_first", stb_t[n], 300);
            chk("b2b_second", stb_t[n+1], 303);
        end
        chk("b2b_late_cnt", late_cnt, 3);
        chk("b2b_envstart", envstart, 12'h301);

        // Reset mid-WAIT
        tcnt = 140; n = stb_t.size();
        valid = 1; cmd = mk(160, 12'h160, 12'h016, 9'h061, 17'h01600, 16'h1600, 16'h0160, 2'd3);
        cycle();
        valid = 0;
        run_until(150);
        rst = 1;
        cycle();
        chk("rst_mid_erst", elem_reset, 1);
        cycle();
        rst = 0;
        cycle();
        chk("rst_mid_erst_low", elem_reset, 0);
        chk("rst_mid_ready", ready, 1);
        run_until(175);
        chk("rst_mid_no_stb", stb_t.size() - n, 0);
        chk("rst_mid_late_cnt", late_cnt, 0);
        chk("rst_mid_fields", {envstart, ampx, mode}, 0);

        // Randomized traffic
        valid = 0;
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            busy = ($urandom_range(0, 3) == 0);
            if (!valid || m_accepted) begin
                valid = $urandom_range(0, 1);
                off   = int'($urandom_range(0, 40)) - 10;
                tt    = tcnt + 27'(off);
                cmd   = mk(tt, 12'($urandom), 12'($urandom), 9'($urandom), 17'($urandom),
                           16'($urandom), 16'($urandom), 2'($urandom));
            end
            cycle();
        end
        rst = 0; valid = 0; busy = 0;
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
